// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor state encoding for the
// traffic conflict monitor.
package traffic_pkg;

   localparam int unsigned LAMP_W  = 3;
   localparam int unsigned FCODE_W = 2;

   // Lamp code: bit2=red, bit1=yellow, bit0=green
   localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
   localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
   localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
   localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

   localparam logic [FCODE_W-1:0] FLT_NONE     = 2'd0;
   localparam logic [FCODE_W-1:0] FLT_ENC      = 2'd1;
   localparam logic [FCODE_W-1:0] FLT_CONFLICT = 2'd2;
   localparam logic [FCODE_W-1:0] FLT_SEQ      = 2'd3;

   typedef enum logic {
      MONITOR = 1'b0,
      FAULT   = 1'b1
   } mon_state_e;

   // True only for the three single-lamp codes
   function automatic logic lamp_legal(input logic [LAMP_W-1:0] lamp);
      return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
   endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// Per-direction lamp sequence checker.
//   clk, reset  : clock, synchronous active-low reset
//   clr         : clears the yellow run counter (fault clear accepted)
//   lamp_in     : current lamp code for this direction
//   enc_err     : lamp_in is not a legal single-lamp code (combinational)
//   seq_err     : previous->current transition is illegal (combinational)
module lamp_seq_checker
   import traffic_pkg::*;
#(
   parameter int unsigned MIN_YELLOW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [LAMP_W-1:0] lamp_in,
   output logic              enc_err,
   output logic              seq_err
);

   localparam int unsigned YCNT_W = $clog2(MIN_YELLOW + 1);

   logic [LAMP_W-1:0] prev_q, prev_d;
   logic [YCNT_W-1:0] ycnt_q, ycnt_d;

   // Previous lamp tracks the input; yellow run saturates at MIN_YELLOW
   always_comb begin
      prev_d = lamp_in;
      ycnt_d = '0;
      if (!clr && (lamp_in == LAMP_YEL)) begin
         if (ycnt_q == YCNT_W'(MIN_YELLOW)) ycnt_d = ycnt_q;
         else                               ycnt_d = ycnt_q + YCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_q <= LAMP_RED;
         ycnt_q <= '0;
      end else begin
         prev_q <= prev_d;
         ycnt_q <= ycnt_d;
      end
   end

   // Legal moves: hold, G->Y, Y->R after a full yellow, R->G
   always_comb begin
      enc_err = !lamp_legal(lamp_in);
      seq_err = 1'b1;
      if (lamp_in == prev_q) begin
         seq_err = 1'b0;
      end else begin
         case (prev_q)
            LAMP_GRN: seq_err = (lamp_in != LAMP_YEL);
            LAMP_YEL: seq_err = !((lamp_in == LAMP_RED) && (ycnt_q >= YCNT_W'(MIN_YELLOW)));
            LAMP_RED: seq_err = (lamp_in != LAMP_GRN);
            default:  seq_err = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between traffic_controller and the lamp drivers. Passes lamp
// codes through with one cycle of latency, and on an encoding, conflict or
// sequencing fault latches the first fault code and flashes red on both
// directions until an operator clear is accepted with both inputs red.
//   clk, reset     : clock, synchronous active-low reset
//   ns_in, ew_in   : lamp codes from traffic_controller
//   fault_clr      : operator request to leave fault mode
//   ns_out, ew_out : registered lamp codes to the drivers
//   fault          : registered, high while in fault mode
//   fault_code     : registered first-fault code (0 when not faulted)
module traffic_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned MIN_YELLOW = 3,
   parameter int unsigned FLASH_HALF = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LAMP_W-1:0]  ns_in,
   input  logic [LAMP_W-1:0]  ew_in,
   input  logic               fault_clr,
   output logic [LAMP_W-1:0]  ns_out,
   output logic [LAMP_W-1:0]  ew_out,
   output logic               fault,
   output logic [FCODE_W-1:0] fault_code
);

   localparam int unsigned FLASH_PERIOD = 2 * FLASH_HALF;
   localparam int unsigned FLASH_W      = $clog2(FLASH_PERIOD);

   mon_state_e         state_q, state_d;
   logic [FLASH_W-1:0] flash_q, flash_d;
   logic [LAMP_W-1:0]  ns_out_q, ns_out_d;
   logic [LAMP_W-1:0]  ew_out_q, ew_out_d;
   logic               fault_q, fault_d;
   logic [FCODE_W-1:0] code_q, code_d;

   logic               clr_c;
   logic               ns_enc, ns_seq, ew_enc, ew_seq;
   logic               conflict_c, clr_ok_c;
   logic [FCODE_W-1:0] det_code_c;

   lamp_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns_chk (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_c),
      .lamp_in (ns_in),
      .enc_err (ns_enc),
      .seq_err (ns_seq)
   );

   lamp_seq_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew_chk (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_c),
      .lamp_in (ew_in),
      .enc_err (ew_enc),
      .seq_err (ew_seq)
   );

   // Prioritised fault detection: encoding, then conflict, then sequence
   always_comb begin
      conflict_c = (ns_in != LAMP_RED) && (ew_in != LAMP_RED);
      clr_ok_c   = fault_clr && (ns_in == LAMP_RED) && (ew_in == LAMP_RED);
      if (ns_enc || ew_enc)      det_code_c = FLT_ENC;
      else if (conflict_c)       det_code_c = FLT_CONFLICT;
      else if (ns_seq || ew_seq) det_code_c = FLT_SEQ;
      else                       det_code_c = FLT_NONE;
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state_q;
      flash_d  = flash_q;
      ns_out_d = ns_in;
      ew_out_d = ew_in;
      fault_d  = fault_q;
      code_d   = code_q;
      clr_c    = 1'b0;
      case (state_q)
         MONITOR: begin
            if (det_code_c != FLT_NONE) begin
               state_d  = FAULT;
               fault_d  = 1'b1;
               code_d   = det_code_c;
               flash_d  = '0;
               ns_out_d = LAMP_RED;
               ew_out_d = LAMP_RED;
            end
         end
         FAULT: begin
            if (clr_ok_c) begin
               state_d = MONITOR;
               fault_d = 1'b0;
               code_d  = FLT_NONE;
               flash_d = '0;
               clr_c   = 1'b1;
            end else begin
               if (flash_q == FLASH_W'(FLASH_PERIOD - 1)) flash_d = '0;
               else                                        flash_d = flash_q + FLASH_W'(1);
               // First half of the flash period is red, second half dark
               ns_out_d = (flash_d < FLASH_W'(FLASH_HALF)) ? LAMP_RED : LAMP_OFF;
               ew_out_d = ns_out_d;
            end
         end
         default: state_d = MONITOR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= MONITOR;
         flash_q  <= '0;
         ns_out_q <= LAMP_RED;
         ew_out_q <= LAMP_RED;
         fault_q  <= 1'b0;
         code_q   <= FLT_NONE;
      end else begin
         state_q  <= state_d;
         flash_q  <= flash_d;
         ns_out_q <= ns_out_d;
         ew_out_q <= ew_out_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
      end
   end

   assign ns_out     = ns_out_q;
   assign ew_out     = ew_out_q;
   assign fault      = fault_q;
   assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Testbench for traffic_conflict_monitor: directed vector table followed by
// randomized traffic checked against a behavioural model.
module tb_traffic_conflict_monitor;
   import traffic_pkg::*;

   localparam int MIN_Y = 3;
   localparam int FH    = 4;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] ns_in, ew_in;
   logic       fault_clr;
   logic [2:0] ns_out, ew_out;
   logic       fault;
   logic [1:0] fault_code;

   always #5 clk = ~clk;

   traffic_conflict_monitor #(.MIN_YELLOW(MIN_Y), .FLASH_HALF(FH)) dut (
      .clk        (clk),
      .reset      (reset),
      .ns_in      (ns_in),
      .ew_in      (ew_in),
      .fault_clr  (fault_clr),
      .ns_out     (ns_out),
      .ew_out     (ew_out),
      .fault      (fault),
      .fault_code (fault_code)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: unsaturated yellow run lengths and cycles since fault
   logic [2:0] m_prev [2];
   int         m_yrun [2];
   bit         m_fault;
   int         m_code;
   int         m_age;
   logic [2:0] m_ns_o, m_ew_o;

   function automatic bit legal_code(input logic [2:0] c);
      return (c == R) || (c == Y) || (c == G);
   endfunction

   function automatic bit legal_step(input logic [2:0] p, input logic [2:0] c, input int yrun);
      if (p == c)           return 1'b1;
      if (p == G && c == Y) return 1'b1;
      if (p == Y && c == R) return yrun >= MIN_Y;
      if (p == R && c == G) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge(input logic [2:0] ns, input logic [2:0] ew,
                             input logic clr, input logic rst);
      logic [2:0] in_l [2];
      int         code;
      in_l[0] = ns;
      in_l[1] = ew;
      if (!rst) begin
         m_fault = 1'b0; m_code = 0; m_age = 0;
         m_ns_o = R; m_ew_o = R;
         for (int i = 0; i < 2; i++) begin m_prev[i] = R; m_yrun[i] = 0; end
      end else begin
         if (!m_fault) begin
            code = 0;
            if (!legal_code(ns) || !legal_code(ew))     code = 1;
            else if (ns != R && ew != R)                code = 2;
            else if (!legal_step(m_prev[0], ns, m_yrun[0]) ||
                     !legal_step(m_prev[1], ew, m_yrun[1])) code = 3;
            if (code != 0) begin
               m_fault = 1'b1; m_code = code; m_age = 0;
               m_ns_o = R; m_ew_o = R;
            end else begin
               m_ns_o = ns; m_ew_o = ew;
            end
         end else if (clr && ns == R && ew == R) begin
            m_fault = 1'b0; m_code = 0;
            m_ns_o = ns; m_ew_o = ew;
         end else begin
            m_age++;
            m_ns_o = ((m_age % (2 * FH)) < FH) ? R : O;
            m_ew_o = m_ns_o;
         end
         for (int i = 0; i < 2; i++) begin
            m_yrun[i] = (in_l[i] == Y) ? m_yrun[i] + 1 : 0;
            m_prev[i] = in_l[i];
         end
      end
   endtask

   task automatic check(input string tag, input logic [2:0] ens, input logic [2:0] eew,
                        input logic ef, input logic [1:0] ec);
      n_cmp++;
      if ({ns_out, ew_out, fault, fault_code} !== {ens, eew, ef, ec}) begin
         n_bad++;
         $display("FAIL %s: got ns=%b ew=%b fault=%b code=%0d, expected ns=%b ew=%b fault=%b code=%0d",
                  tag, ns_out, ew_out, fault, fault_code, ens, eew, ef, ec);
      end
   endtask

   // Drive before the edge, update the model at the edge, settle for sampling
   task automatic drive(input logic [2:0] ns, input logic [2:0] ew,
                        input logic clr, input logic rst);
      @(negedge clk);
      ns_in = ns; ew_in = ew; fault_clr = clr; reset = rst;
      @(posedge clk);
      model_edge(ns, ew, clr, rst);
      #1;
   endtask

   typedef struct {
      logic [2:0] ns, ew;
      logic       clr, rst;
      logic [2:0] ens, eew;
      logic       ef;
      logic [1:0] ec;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [2:0] ns, input logic [2:0] ew, input logic clr,
                      input logic rst, input logic [2:0] ens, input logic [2:0] eew,
                      input logic ef, input logic [1:0] ec);
      vec_t v;
      v.ns = ns; v.ew = ew; v.clr = clr; v.rst = rst;
      v.ens = ens; v.eew = eew; v.ef = ef; v.ec = ec;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b0; ns_in = R; ew_in = R; fault_clr = 1'b0;
      m_fault = 1'b0; m_code = 0; m_age = 0; m_ns_o = R; m_ew_o = R;
      for (int i = 0; i < 2; i++) begin m_prev[i] = R; m_yrun[i] = 0; end

      //   ns ew clr rst   ns_o ew_o f code
      add(G, R, 0, 0,   R, R, 0, 0);   // reset held two cycles
      add(G, R, 0, 0,   R, R, 0, 0);
      add(G, R, 0, 1,   G, R, 0, 0);   // legal NS cycle
      add(Y, R, 0, 1,   Y, R, 0, 0);
      add(Y, R, 0, 1,   Y, R, 0, 0);
      add(Y, R, 0, 1,   Y, R, 0, 0);
      add(R, R, 0, 1,   R, R, 0, 0);   // Y->R after full yellow
      add(R, G, 0, 1,   R, G, 0, 0);
      add(R, G, 0, 1,   R, G, 0, 0);
      add(G, G, 0, 1,   R, R, 1, 2);   // conflict
      add(G, G, 0, 1,   R, R, 1, 2);
      add(G, G, 0, 1,   R, R, 1, 2);
      add(G, G, 0, 1,   R, R, 1, 2);
      add(G, G, 0, 1,   O, O, 1, 2);
      add(G, G, 0, 1,   O, O, 1, 2);
      add(G, G, 0, 1,   O, O, 1, 2);
      add(G, G, 0, 1,   O, O, 1, 2);
      add(G, G, 0, 1,   R, R, 1, 2);   // flash repeats
      add(R, G, 1, 1,   R, R, 1, 2);   // clear ignored, EW green
      add(R, R, 1, 1,   R, R, 0, 0);   // clear accepted
      add(G, R, 0, 1,   G, R, 0, 0);   // pass-through resumes
      add(Y, R, 0, 1,   Y, R, 0, 0);
      add(Y, R, 0, 1,   Y, R, 0, 0);
      add(R, R, 0, 1,   R, R, 1, 3);   // short yellow
      add(R, R, 1, 1,   R, R, 0, 0);
      add(G, R, 0, 1,   G, R, 0, 0);
      add(R, R, 0, 1,   R, R, 1, 3);   // G->R direct
      add(R, R, 1, 1,   R, R, 0, 0);
      add(3'b011, G, 0, 1, R, R, 1, 1); // encoding beats conflict
      add(G, G, 0, 1,   R, R, 1, 1);   // later conflict keeps code 1
      add(G, G, 0, 1,   R, R, 1, 1);
      add(G, G, 0, 1,   R, R, 1, 1);
      add(G, G, 0, 1,   O, O, 1, 1);
      add(G, G, 0, 0,   R, R, 0, 0);   // reset mid-flash
      add(R, R, 0, 1,   R, R, 0, 0);
      add(R, G, 1, 1,   R, G, 0, 0);   // clear in monitor: no effect
      add(R, Y, 0, 1,   R, Y, 0, 0);
      add(R, R, 1, 1,   R, R, 1, 3);   // fault wins over clear (short yellow)
      add(R, R, 0, 0,   R, R, 0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].ns, tbl[i].ew, tbl[i].clr, tbl[i].rst);
         check($sformatf("vec%0d", i), tbl[i].ens, tbl[i].eew, tbl[i].ef, tbl[i].ec);
         check($sformatf("vec%0d_model", i), m_ns_o, m_ew_o, m_fault, 2'(m_code));
      end

      // Randomized traffic: mostly legal phase program with injected faults
      begin
         int ph;
         int left;
         ph = 0;
         left = 3;
         for (int i = 0; i < 1500; i++) begin
            logic [2:0] ns;
            logic [2:0] ew;
            logic       clr;
            logic       rst;
            case (ph)
               0:       begin ns = G; ew = R; end
               1:       begin ns = Y; ew = R; end
               2:       begin ns = R; ew = G; end
               default: begin ns = R; ew = Y; end
            endcase
            left--;
            if (left == 0) begin
               ph = (ph + 1) % 4;
               left = (ph == 1 || ph == 3) ? int'($urandom_range(2, 4)) : int'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 99) < 3) ns = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 2) ew = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) != 0);
            if (m_fault && $urandom_range(0, 5) == 0) begin
               ns = R; ew = R; clr = 1'b1;
               ph = 0; left = int'($urandom_range(1, 6));
            end
            if (!rst) begin ph = 0; left = int'($urandom_range(1, 6)); end
            drive(ns, ew, clr, rst);
            check($sformatf("rnd%0d", i), m_ns_o, m_ew_o, m_fault, 2'(m_code));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
